// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: command ports A/B and the shared read-response channel.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
interface regfile_port_arbiter_if;
  localparam int unsigned OPW  = 2;
  localparam int unsigned SELW = 3;
  localparam int unsigned DW   = 8;

  logic            a_valid;
  logic            a_ready;
  logic [OPW-1:0]  a_op;
  logic [SELW-1:0] a_sel;
  logic [DW-1:0]   a_wdata;

  logic            b_valid;
  logic            b_ready;
  logic [OPW-1:0]  b_op;
  logic [SELW-1:0] b_sel;
  logic [DW-1:0]   b_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_id;
  logic [DW-1:0]   rsp_d1;
  logic [DW-1:0]   rsp_d2;
  logic            rsp_err;

  modport master (
    output a_valid, a_op, a_sel, a_wdata,
    input  a_ready,
    output b_valid, b_op, b_sel, b_wdata,
    input  b_ready,
    input  rsp_valid, rsp_id, rsp_d1, rsp_d2, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  a_valid, a_op, a_sel, a_wdata,
    output a_ready,
    input  b_valid, b_op, b_sel, b_wdata,
    output b_ready,
    output rsp_valid, rsp_id, rsp_d1, rsp_d2, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: sequences write/read/pair-read/move commands from two ports
// onto the 8x8 register stack, one at a time, and returns read data on a response channel.
// Build option: RFARB_RR_EN selects round-robin tie-breaking; undefined gives port A priority.
module regfile_port_arbiter #(
  parameter logic [2:0] IDLE_REGSEL = 3'd4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_port_arbiter_if.slave bus,
  output logic                  busy,
  output logic [1:0]            rf_ropsel,
  output logic [2:0]            rf_regsel,
  output logic [7:0]            rf_rdatain,
  input  logic [7:0]            rf_rdataout1,
  input  logic [7:0]            rf_rdataout2
);

  localparam int unsigned OPW  = 2;
  localparam int unsigned SELW = 3;
  localparam int unsigned DW   = 8;

  localparam logic [OPW-1:0] OP_WR   = 2'd0;
  localparam logic [OPW-1:0] OP_RD1  = 2'd1;
  localparam logic [OPW-1:0] OP_RD2  = 2'd2;
  localparam logic [OPW-1:0] OP_MOVE = 2'd3;
  // Pair read with regsel 4..7 leaves the stack's read outputs untouched.
  localparam logic [OPW-1:0] ROP_IDLE = OP_RD2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            win_b;
  logic [OPW-1:0]  win_op;
  logic [SELW-1:0] win_sel;
  logic [DW-1:0]   win_wdata;
  logic [OPW-1:0]  op_q;
  logic [SELW-1:0] sel_q;
  logic            id_q;
`ifdef RFARB_RR_EN
  logic            last_b;
`endif

  // Tie-break between the two requesters.
  always_comb begin
    win_b = 1'b0;
`ifdef RFARB_RR_EN
    if (bus.a_valid && bus.b_valid) begin
      win_b = ~last_b;
    end else begin
      win_b = bus.b_valid;
    end
`else
    win_b = bus.b_valid && !bus.a_valid;
`endif
  end

  assign win_op    = win_b ? bus.b_op    : bus.a_op;
  assign win_sel   = win_b ? bus.b_sel   : bus.a_sel;
  assign win_wdata = win_b ? bus.b_wdata : bus.a_wdata;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and accept decision.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.a_valid || bus.b_valid) begin
          accept    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = (op_q == OP_RD1 || op_q == OP_RD2) ? S_CAPT : S_IDLE;
      end
      S_CAPT: begin
        state_nxt = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Ready is combinational so the winner sees its handshake in the accept cycle.
  assign bus.a_ready = accept & ~win_b;
  assign bus.b_ready = accept &  win_b;

  // Command latch, stack drive, response capture and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= OP_WR;
      sel_q         <= '0;
      id_q          <= 1'b0;
      rf_ropsel     <= ROP_IDLE;
      rf_regsel     <= IDLE_REGSEL;
      rf_rdatain    <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_d1    <= '0;
      bus.rsp_d2    <= '0;
      bus.rsp_err   <= 1'b0;
      busy          <= 1'b0;
`ifdef RFARB_RR_EN
      last_b        <= 1'b1;
`endif
    end else begin
      if (accept) begin
        op_q       <= win_op;
        sel_q      <= win_sel;
        id_q       <= win_b;
        rf_ropsel  <= win_op;
        rf_regsel  <= win_sel;
        rf_rdatain <= win_wdata;
`ifdef RFARB_RR_EN
        last_b     <= win_b;
`endif
      end else begin
        rf_ropsel  <= ROP_IDLE;
        rf_regsel  <= IDLE_REGSEL;
        rf_rdatain <= '0;
      end
      if (state == S_CAPT) begin
        bus.rsp_d1  <= rf_rdataout1;
        bus.rsp_d2  <= (op_q == OP_RD1) ? DW'(0) : rf_rdataout2;
        bus.rsp_err <= (op_q == OP_RD2) && sel_q[2];
        bus.rsp_id  <= id_q;
      end
      bus.rsp_valid <= (state_nxt == S_RESP);
      busy          <= (state_nxt != S_IDLE);
    end
  end

  // Move is handled entirely by the stack; the constant is kept for readability of op decoding.
  logic unused_ok;
  assign unused_ok = (OP_MOVE == 2'd3);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed table, hand-written corner sequences and random
// commands against a transaction-level model of the register stack.
module tb_regfile_port_arbiter;

  localparam logic [2:0] IDLE_SEL = 3'd4;
  localparam logic [7:0] ALU6 = 8'hA6;
  localparam logic [7:0] ALU7 = 8'hA7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       busy;
  logic [1:0] rf_ropsel;
  logic [2:0] rf_regsel;
  logic [7:0] rf_rdatain;
  logic [7:0] rf_rdataout1;
  logic [7:0] rf_rdataout2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  regfile_port_arbiter_if bus ();

  regfile_port_arbiter #(.IDLE_REGSEL(IDLE_SEL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .busy         (busy),
    .rf_ropsel    (rf_ropsel),
    .rf_regsel    (rf_regsel),
    .rf_rdatain   (rf_rdatain),
    .rf_rdataout1 (rf_rdataout1),
    .rf_rdataout2 (rf_rdataout2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-level register stack: every opcode acts on each edge; regs 6/7 follow ALU inputs.
  logic [7:0] stk [8];
  logic [7:0] out1, out2;
  assign rf_rdataout1 = out1;
  assign rf_rdataout2 = out2;

  initial begin
    for (int i = 0; i < 8; i++) stk[i] = 8'h00;
    stk[6] = ALU6;
    stk[7] = ALU7;
    out1 = 8'h00;
    out2 = 8'h00;
  end

  always @(posedge clk) begin
    case (rf_ropsel)
      2'd0: stk[rf_regsel] <= rf_rdatain;
      2'd1: out1 <= stk[rf_regsel];
      2'd2: if (!rf_regsel[2]) begin
              out1 <= stk[{rf_regsel[1:0], 1'b0}];
              out2 <= stk[{rf_regsel[1:0], 1'b1}];
            end
      default: stk[0] <= stk[rf_regsel];
    endcase
    if (!(rf_ropsel == 2'd0 && rf_regsel == 3'd6)) stk[6] <= ALU6;
    if (!(rf_ropsel == 2'd0 && rf_regsel == 3'd7)) stk[7] <= ALU7;
  end

  // Transaction-level reference: register contents and the stack's held read outputs.
  logic [7:0] m_reg [8];
  logic [7:0] m_o1, m_o2;

  task automatic model_init();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
    m_reg[6] = ALU6;
    m_reg[7] = ALU7;
    m_o1 = 8'h00;
    m_o2 = 8'h00;
  endtask

  task automatic model_step(input logic [1:0] op, input logic [2:0] sel, input logic [7:0] wd,
                            output logic [7:0] e1, output logic [7:0] e2, output logic eerr);
    e1 = 8'h00;
    e2 = 8'h00;
    eerr = 1'b0;
    if (op == 2'd0) begin
      m_reg[sel] = wd;
    end else if (op == 2'd1) begin
      m_o1 = m_reg[sel];
      e1 = m_o1;
    end else if (op == 2'd2) begin
      if (sel < 3'd4) begin
        m_o1 = m_reg[2 * sel];
        m_o2 = m_reg[2 * sel + 1];
      end
      e1 = m_o1;
      e2 = m_o2;
      eerr = (sel >= 3'd4);
    end else begin
      m_reg[0] = m_reg[sel];
    end
    // ALU inputs overwrite 6/7 long before any later command can observe them.
    m_reg[6] = ALU6;
    m_reg[7] = ALU7;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit port, input logic v, input logic [1:0] op,
                       input logic [2:0] sel, input logic [7:0] wd);
    if (!port) begin
      bus.a_valid = v; bus.a_op = op; bus.a_sel = sel; bus.a_wdata = wd;
    end else begin
      bus.b_valid = v; bus.b_op = op; bus.b_sel = sel; bus.b_wdata = wd;
    end
  endtask

  // One command end to end with cycle-exact checks; entered and left at posedge+1.
  task automatic run_cmd(input bit port, input logic [1:0] op, input logic [2:0] sel,
                         input logic [7:0] wd, input int hold,
                         input logic [7:0] e1, input logic [7:0] e2, input logic eerr);
    int n;
    bus.rsp_ready = (hold == 0);
    drive(port, 1'b1, op, sel, wd);
    n = 0;
    @(negedge clk);
    while (!(port ? bus.b_ready : bus.a_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 8'(n < 20), 8'd1);
    @(posedge clk); #1;
    drive(port, 1'b0, 2'd0, 3'd0, 8'h00);
    @(negedge clk);
    chk("issue ropsel", 8'(rf_ropsel), 8'(op));
    chk("issue regsel", 8'(rf_regsel), 8'(sel));
    chk("issue busy", 8'(busy), 8'd1);
    chk("issue rsp_valid", 8'(bus.rsp_valid), 8'd0);
    if (op == 2'd0) chk("issue rdatain", rf_rdatain, wd);
    if (op == 2'd0 || op == 2'd3) begin
      @(negedge clk);
      chk("wr done busy", 8'(busy), 8'd0);
      chk("wr done ropsel", 8'(rf_ropsel), 8'd2);
      chk("wr rsp_valid", 8'(bus.rsp_valid), 8'd0);
    end else begin
      @(negedge clk);
      chk("capt rsp_valid", 8'(bus.rsp_valid), 8'd0);
      chk("capt ropsel", 8'(rf_ropsel), 8'd2);
      chk("capt regsel", 8'(rf_regsel), 8'(IDLE_SEL));
      for (int h = 0; h <= hold; h++) begin
        @(negedge clk);
        chk("rsp_valid", 8'(bus.rsp_valid), 8'd1);
        chk("rsp_d1", bus.rsp_d1, e1);
        chk("rsp_d2", bus.rsp_d2, e2);
        chk("rsp_err", 8'(bus.rsp_err), 8'(eerr));
        chk("rsp_id", 8'(bus.rsp_id), 8'(port));
        @(posedge clk); #1;
        if (h + 1 == hold) bus.rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk("rsp done valid", 8'(bus.rsp_valid), 8'd0);
      chk("rsp done busy", 8'(busy), 8'd0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
  endtask

  typedef struct {
    bit         port;
    logic [1:0] op;
    logic [2:0] sel;
    logic [7:0] wd;
    int         hold;
    logic [7:0] e1;
    logic [7:0] e2;
    logic       eerr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [7:0] e1, e2;
    logic eerr;
    bit ord [$];
    int na, nb, last_acc;
    bit exp_b;

    tbl[0]  = '{1'b0, 2'd0, 3'd3, 8'h5A, 0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 3'd3, 8'h00, 0, 8'h5A, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 3'd0, 8'h11, 0, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 3'd1, 8'h22, 0, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 2'd2, 3'd0, 8'h00, 4, 8'h11, 8'h22, 1'b0};
    tbl[5]  = '{1'b0, 2'd2, 3'd5, 8'h00, 0, 8'h11, 8'h22, 1'b1};
    tbl[6]  = '{1'b0, 2'd0, 3'd6, 8'h77, 0, 8'h00, 8'h00, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 3'd6, 8'h00, 0, 8'hA6, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 3'd3, 8'h00, 0, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{1'b0, 2'd1, 3'd0, 8'h00, 0, 8'h5A, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 2'd2, 3'd1, 8'h00, 0, 8'h00, 8'h5A, 1'b0};
    tbl[11] = '{1'b0, 2'd2, 3'd3, 8'h00, 1, 8'hA6, 8'hA7, 1'b0};
    tbl[12] = '{1'b1, 2'd2, 3'd7, 8'h00, 0, 8'hA6, 8'hA7, 1'b1};

    model_init();
    drive(1'b0, 1'b0, 2'd0, 3'd0, 8'h00);
    drive(1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
    bus.rsp_ready = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst a_ready", 8'(bus.a_ready), 8'd0);
    chk("rst b_ready", 8'(bus.b_ready), 8'd0);
    chk("rst rsp_valid", 8'(bus.rsp_valid), 8'd0);
    chk("rst rsp_err", 8'(bus.rsp_err), 8'd0);
    chk("rst rsp_id", 8'(bus.rsp_id), 8'd0);
    chk("rst busy", 8'(busy), 8'd0);
    chk("rst rsp_d1", bus.rsp_d1, 8'h00);
    chk("rst rsp_d2", bus.rsp_d2, 8'h00);
    chk("rst ropsel", 8'(rf_ropsel), 8'd2);
    chk("rst regsel", 8'(rf_regsel), 8'(IDLE_SEL));
    chk("rst rdatain", rf_rdatain, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      model_step(tbl[i].op, tbl[i].sel, tbl[i].wd, e1, e2, eerr);
      run_cmd(tbl[i].port, tbl[i].op, tbl[i].sel, tbl[i].wd, tbl[i].hold,
              tbl[i].e1, tbl[i].e2, tbl[i].eerr);
    end

    // Simultaneous requesters, four back-to-back writes each, from a fresh reset.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    na = 0; nb = 0; last_acc = -1;
    drive(1'b0, 1'b1, 2'd0, 3'd0, 8'hC0);
    drive(1'b1, 1'b1, 2'd0, 3'd4, 8'hD0);
    for (int c = 0; c < 40 && (na < 4 || nb < 4); c++) begin
      @(negedge clk);
      chk("tie one-hot", 8'(bus.a_ready && bus.b_ready), 8'd0);
      if (bus.a_ready || bus.b_ready) begin
        if (last_acc >= 0) chk("tie spacing", 8'(cyc - last_acc), 8'd2);
        last_acc = cyc;
      end
      if (bus.a_ready) begin
        ord.push_back(1'b0);
        model_step(2'd0, 3'(na), 8'(8'hC0 + na), e1, e2, eerr);
        na++;
      end else if (bus.b_ready) begin
        ord.push_back(1'b1);
        model_step(2'd0, 3'(4 + nb), 8'(8'hD0 + nb), e1, e2, eerr);
        nb++;
      end
      @(posedge clk); #1;
      if (na >= 4) drive(1'b0, 1'b0, 2'd0, 3'd0, 8'h00);
      else drive(1'b0, 1'b1, 2'd0, 3'(na), 8'(8'hC0 + na));
      if (nb >= 4) drive(1'b1, 1'b0, 2'd0, 3'd0, 8'h00);
      else drive(1'b1, 1'b1, 2'd0, 3'(4 + nb), 8'(8'hD0 + nb));
    end
    chk("tie grant count", 8'(ord.size()), 8'd8);
    for (int i = 0; i < 8; i++) begin
`ifdef RFARB_RR_EN
      exp_b = 1'(i % 2);
`else
      exp_b = (i >= 4);
`endif
      chk("tie order", 8'(i < ord.size() ? ord[i] : 1'bx), 8'(exp_b));
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset while a response is pending.
    bus.rsp_ready = 1'b0;
    model_step(2'd1, 3'd4, 8'h00, e1, e2, eerr);
    drive(1'b0, 1'b1, 2'd1, 3'd4, 8'h00);
    na = 0;
    @(negedge clk);
    while (!bus.a_ready && na < 20) begin
      @(negedge clk);
      na++;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'd0, 3'd0, 8'h00);
    na = 0;
    @(negedge clk);
    while (!bus.rsp_valid && na < 10) begin
      @(negedge clk);
      na++;
    end
    chk("pre-rst rsp_valid", 8'(bus.rsp_valid), 8'd1);
    chk("pre-rst rsp_d1", bus.rsp_d1, e1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst resp rsp_valid", 8'(bus.rsp_valid), 8'd0);
    chk("rst resp ropsel", 8'(rf_ropsel), 8'd2);
    chk("rst resp regsel", 8'(rf_regsel), 8'(IDLE_SEL));
    chk("rst resp busy", 8'(busy), 8'd0);
    #2 rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    model_step(2'd1, 3'd4, 8'h00, e1, e2, eerr);
    run_cmd(1'b1, 2'd1, 3'd4, 8'h00, 0, e1, e2, eerr);

    // Random single-requester commands against the reference model.
    for (int i = 0; i < 60; i++) begin
      bit p;
      logic [1:0] op;
      logic [2:0] sel;
      logic [7:0] wd;
      int hold;
      p = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3));
      sel = 3'($urandom_range(0, 7));
      wd = 8'($urandom);
      hold = $urandom_range(0, 2);
      model_step(op, sel, wd, e1, e2, eerr);
      run_cmd(p, op, sel, (op == 2'd0) ? wd : 8'h00, hold, e1, e2, eerr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
